rnn_mem_arbiter: RTL
====================

// Module: rnn_mem_arbiter
// PURPOSE
//  Shares the single weight/result memory port (mce/msel/maddr/mdata_w/mdata_r) between
//  two requesters: req0 = RNN compute core, req1 = host loader/readback engine.
//  Round-robin grant, registered memory-side outputs, tagged read-data return.
//  Sits between the RNN core and the external memory macro.
// PARAMETERS
//  AW      17      memory address width (maddr)
//  DW      20      memory data width (mdata_r/mdata_w)
//  RD_LAT  1       cycles from issue on maddr to valid mdata_r (1..4)
//  WR_SEL  3'b101  msel code meaning "write"; every other msel code is a read
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active-high
//  req0/req1  in   1    request valid, held until granted
//  sel0/sel1  in   3    msel code for request
//  addr0/addr1 in  AW   address for request
//  wdata0/wdata1 in DW  write data (used when sel==WR_SEL)
//  lock1      in   1    burst lock from requester 1 (effective only with RNN_ARB_LOCK_EN)
//  gnt0/gnt1  out  1    combinational grant; request accepted on cycle with req&&gnt
//  rvalid0/rvalid1 out 1 read data valid for that requester, one cycle pulse
//  rdata      out  DW   returned read data (shared, qualify with rvalidN)
//  mce        out  1    memory chip enable, registered
//  msel       out  3    memory select, registered
//  maddr      out  AW   memory address, registered
//  mdata_w    out  DW   memory write data, registered
//  mdata_r    in   DW   memory read data
// BEHAVIOUR
//  - Reset (async): mce=0, msel=3'b100, maddr=0, mdata_w=0, gnt*=0, rvalid*=0, rdata=0,
//    last-winner pointer=1 (req0 wins first tie), read tag pipeline cleared.
//  - Arbitration: at most one grant per cycle. Single requester -> granted same cycle.
//    Both requesting -> grant the one not granted last; pointer updates only on accept.
//  - Issue: accepted request drives mce=1, msel, maddr, mdata_w on the next edge (1-cycle
//    latency). Cycles with no accept: mce=0; msel/maddr/mdata_w hold previous values.
//  - Reads (sel!=WR_SEL): tag {valid, id} enters an RD_LAT-deep shift register at issue;
//    when tag exits, rvalidN=1 for the matching id and rdata=mdata_r sampled that cycle.
//    Total req-accept-to-rvalid latency = 1+RD_LAT cycles; back-to-back reads sustain
//    one per cycle, returns in issue order, no gaps.
//  - Writes (sel==WR_SEL): no rvalid; write occurs at issue cycle.
//  - Req dropped before grant: no effect; no state retained. Req with gnt=0 is
//    retried by requester (hold all fields stable).
//  - Reset mid-operation: in-flight tags discarded; no rvalid emitted after reset deasserts.
//  - Fairness bound: a continuously requesting requester waits at most 1 cycle
//    (without lock).
// CONFIGURATION
//  RNN_ARB_LOCK_EN defined: when requester 1 is granted with lock1=1, grant is
//    pinned to requester 1 on every following cycle while lock1 stays 1 (gnt0=0 even
//    if req0); pin releases the cycle after lock1=0 or req1=0. Used for atomic
//    host burst loads of one weight row (32/64 words).
//  RNN_ARB_LOCK_EN undefined: lock1 ignored; pure round-robin.
// TESTING
//  1. Reset mid-read (RD_LAT=2, read issued, reset 1 cycle later) -> rvalid0/1 stay 0,
//     mce=0, msel=3'b100 after reset.
//  2. req0 alone, sel=3'b010, addr=17'h00041 -> gnt0 same cycle; next cycle mce=1,
//     msel=3'b010, maddr=17'h00041; rvalid0 RD_LAT cycles later with rdata=mdata_r.
//  3. req0&req1 held 6 cycles, both reads -> grants alternate 0,1,0,1,0,1; rvalids
//     alternate in same order, 1+RD_LAT cycles after each accept.
//  4. req1 write sel=3'b101, wdata=20'h0F0F1, addr=17'h1_0040 -> mdata_w=20'h0F0F1 at
//     issue, mce=1, no rvalid1.
//  5. (RNN_ARB_LOCK_EN) req1+lock1 for 4 cycles with req0 held -> gnt1 four consecutive
//     cycles, gnt0 first asserted the cycle after lock1 drops; without macro, alternate.

Source files
------------

// File: rtl/rnn_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared weight/result memory port.
interface rnn_mem_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 20
);
  // reqN is valid, gntN is ready: requester holds reqN and all its fields stable until
  // a cycle with reqN && gntN (accept); gntN is combinational and may depend on reqN.
  logic          req0;
  logic          req1;
  logic [2:0]    sel0;
  logic [2:0]    sel1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          lock1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          mce;
  logic [2:0]    msel;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_w;
  logic [DW-1:0] mdata_r;

  modport slave (
    input  req0, req1, sel0, sel1, addr0, addr1, wdata0, wdata1, lock1, mdata_r,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mce, msel, maddr, mdata_w
  );

  modport master (
    output req0, req1, sel0, sel1, addr0, addr1, wdata0, wdata1, lock1, mdata_r,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mce, msel, maddr, mdata_w
  );
endinterface

// File: rtl/rnn_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the RNN core (req0) and host engine (req1).
// Define RNN_ARB_LOCK_EN to let requester 1 pin the grant for burst loads via lock1.
module rnn_mem_arbiter #(
  parameter int         AW     = 17,
  parameter int         DW     = 20,
  parameter int         RD_LAT = 1,
  parameter logic [2:0] WR_SEL = 3'b101
) (
  input  logic                clk,
  input  logic                reset,
  rnn_mem_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state
);

`ifdef RNN_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ARB_PIN1 implies requester 1 won last and holds a burst lock.
  typedef enum logic [1:0] {
    ARB_LAST0 = 2'd0,
    ARB_LAST1 = 2'd1,
    ARB_PIN1  = 2'd2
  } arb_state_t;

  arb_state_t    state_q, state_d;
  logic          gnt0_c, gnt1_c;
  logic          gnt0, gnt1, acc, rd_acc;
  logic [2:0]    sel_m;
  logic [AW-1:0] addr_m;
  logic [DW-1:0] wdata_m;
  logic [RD_LAT:0] tag_v;
  logic [RD_LAT:0] tag_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_LAST1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    case (state_q)
      ARB_LAST0: begin
        gnt1_c = bus.req1;
        gnt0_c = bus.req0 && !bus.req1;
      end
      ARB_PIN1: begin
        gnt1_c = bus.req1;
      end
      default: begin
        gnt0_c = bus.req0;
        gnt1_c = bus.req1 && !bus.req0;
      end
    endcase
    if (gnt0_c)                  state_d = ARB_LAST0;
    else if (gnt1_c)             state_d = (LOCK_EN && bus.lock1) ? ARB_PIN1 : ARB_LAST1;
    else if (state_q == ARB_PIN1) state_d = ARB_LAST1;
  end

  assign gnt0      = gnt0_c && !reset;
  assign gnt1      = gnt1_c && !reset;
  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign dbg_state = state_q;

  assign acc     = gnt0 || gnt1;
  assign sel_m   = gnt1 ? bus.sel1   : bus.sel0;
  assign addr_m  = gnt1 ? bus.addr1  : bus.addr0;
  assign wdata_m = gnt1 ? bus.wdata1 : bus.wdata0;
  assign rd_acc  = acc && (sel_m != WR_SEL);

  // Memory-side command register: fields hold when idle, only mce drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mce     <= 1'b0;
      bus.msel    <= 3'b100;
      bus.maddr   <= '0;
      bus.mdata_w <= '0;
    end else begin
      bus.mce <= acc;
      if (acc) begin
        bus.msel    <= sel_m;
        bus.maddr   <= addr_m;
        bus.mdata_w <= wdata_m;
      end
    end
  end

  // Stage 0 rides with the issue cycle; stage RD_LAT lines up with mdata_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[RD_LAT-1:0], rd_acc};
      tag_id <= {tag_id[RD_LAT-1:0], gnt1};
    end
  end

  assign bus.rvalid0 = tag_v[RD_LAT] && !tag_id[RD_LAT];
  assign bus.rvalid1 = tag_v[RD_LAT] &&  tag_id[RD_LAT];
  assign bus.rdata   = tag_v[RD_LAT] ? bus.mdata_r : '0;

endmodule
